// File: rtl/systolic_collector.sv
// Output-side collector for the systolic array: after a start pulse it waits the
// array pipeline latency, captures N consecutive samples of the six array outputs
// and drains them word by word over a valid/ready stream.
module systolic_collector #(
  parameter int unsigned W       = 32,
  parameter int unsigned N       = 10,
  parameter int unsigned LATENCY = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] c14,
  input  logic [W-1:0] s14,
  input  logic [W-1:0] c24,
  input  logic [W-1:0] s24,
  input  logic [W-1:0] x23,
  input  logic [W-1:0] x24,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_data,
  output logic [2:0]   m_sel,
  output logic [3:0]   m_idx,
  output logic         m_last,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [7:0] LatInit = 8'(LATENCY - 1);
  localparam logic [3:0] LastIdx = 4'(N - 1);
  localparam logic [2:0] LastSel = 3'd5;

  typedef enum logic [1:0] {StIdle, StWait, StCapture, StDrain} state_e;

  state_e       state_q, state_d;
  logic [7:0]   lat_cnt_q, lat_cnt_d;
  logic [3:0]   sample_q, sample_d;
  logic [3:0]   idx_q, idx_d;
  logic [2:0]   sel_q, sel_d;
  logic         done_q, done_d;
  logic         err_q, err_d;
  logic         cap_we;

  // Sample buffer: N entries of six words, word order matches the m_sel tag.
  logic [W-1:0] buf_q [N][6];

  // Next-state logic for the frame sequencer and stream pointers.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    sample_d  = sample_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    err_d     = err_q;
    cap_we    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d    = 1'b0;
          sample_d = 4'd0;
          // With a one-cycle latency, sample 0 is already due at the next edge.
          if (LATENCY == 1) begin
            state_d = StCapture;
          end else begin
            state_d   = StWait;
            lat_cnt_d = LatInit;
          end
        end
      end

      StWait: begin
        lat_cnt_d = lat_cnt_q - 8'd1;
        if (lat_cnt_q == 8'd1) begin
          state_d  = StCapture;
          sample_d = 4'd0;
        end
      end

      StCapture: begin
        cap_we   = 1'b1;
        sample_d = sample_q + 4'd1;
        if (sample_q == LastIdx) begin
          state_d  = StDrain;
          sample_d = 4'd0;
          idx_d    = 4'd0;
          sel_d    = 3'd0;
        end
      end

      StDrain: begin
        if (m_ready) begin
          if (sel_q == LastSel) begin
            sel_d = 3'd0;
            if (idx_q == LastIdx) begin
              idx_d   = 4'd0;
              state_d = StIdle;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            sel_d = sel_q + 3'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    // A start outside IDLE never restarts the frame; it only flags the overlap.
    if (start && (state_q != StIdle)) begin
      err_d = 1'b1;
    end
  end

  // Sequencer state, counters and status flags; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      lat_cnt_q <= 8'd0;
      sample_q  <= 4'd0;
      idx_q     <= 4'd0;
      sel_q     <= 3'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      sample_q  <= sample_d;
      idx_q     <= idx_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Capture all six array outputs into the current sample entry.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      buf_q[sample_q][0] <= c14;
      buf_q[sample_q][1] <= s14;
      buf_q[sample_q][2] <= c24;
      buf_q[sample_q][3] <= s24;
      buf_q[sample_q][4] <= x23;
      buf_q[sample_q][5] <= x24;
    end
  end

  // Stream outputs; data is forced to zero outside DRAIN so reset reads all-zero.
  always_comb begin
    m_valid = (state_q == StDrain);
    m_data  = m_valid ? buf_q[idx_q][sel_q] : '0;
    m_sel   = sel_q;
    m_idx   = idx_q;
    m_last  = m_valid && (idx_q == LastIdx) && (sel_q == LastSel);
    busy    = (state_q != StIdle);
    done    = done_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_systolic_collector.sv
// Bench for systolic_collector: a default instance (N=10, LATENCY=8) and a boundary
// instance (N=1, LATENCY=1), driven with random array outputs. Expected frames come
// from a per-edge history of the inputs and the frame timing rules.
module tb_systolic_collector;

  localparam int HMax = 4096;

  typedef struct {
    logic [31:0] d;
    logic [2:0]  s;
    logic [3:0]  i;
    logic        l;
    int          e;
  } xfer_t;

  logic             clk;
  logic             rst;
  logic [1:0]       st;
  logic [1:0]       rdy;
  logic [31:0]      in_c14, in_s14, in_c24, in_s24, in_x23, in_x24;
  logic [1:0]       mv, mlast, mbusy, mdone, merr;
  logic [1:0][31:0] md;
  logic [1:0][2:0]  msel;
  logic [1:0][3:0]  midx;

  logic [31:0] hist [HMax][6];
  xfer_t       xq[$];
  int          edge_n;
  int          act;
  int          n_checks;
  int          n_errors;

  systolic_collector u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .start  (st[0]),
    .c14    (in_c14),
    .s14    (in_s14),
    .c24    (in_c24),
    .s24    (in_s24),
    .x23    (in_x23),
    .x24    (in_x24),
    .m_valid(mv[0]),
    .m_ready(rdy[0]),
    .m_data (md[0]),
    .m_sel  (msel[0]),
    .m_idx  (midx[0]),
    .m_last (mlast[0]),
    .busy   (mbusy[0]),
    .done   (mdone[0]),
    .err    (merr[0])
  );

  systolic_collector #(
    .W      (32),
    .N      (1),
    .LATENCY(1)
  ) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .start  (st[1]),
    .c14    (in_c14),
    .s14    (in_s14),
    .c24    (in_c24),
    .s24    (in_s24),
    .x23    (in_x23),
    .x24    (in_x24),
    .m_valid(mv[1]),
    .m_ready(rdy[1]),
    .m_data (md[1]),
    .m_sel  (msel[1]),
    .m_idx  (midx[1]),
    .m_last (mlast[1]),
    .busy   (mbusy[1]),
    .done   (mdone[1]),
    .err    (merr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // One clock: drive fresh inputs, remember them, then log transfers and stall behaviour.
  task automatic step();
    logic        pre_x, pre_s, pl;
    logic [31:0] pd;
    logic [2:0]  ps;
    logic [3:0]  pi;
    xfer_t       t;
    in_c14 = $urandom;
    in_s14 = $urandom;
    in_c24 = $urandom;
    in_s24 = $urandom;
    in_x23 = 32'h100 + 32'(edge_n + 1);
    in_x24 = $urandom;
    if (edge_n + 1 < HMax) begin
      hist[edge_n+1][0] = in_c14;
      hist[edge_n+1][1] = in_s14;
      hist[edge_n+1][2] = in_c24;
      hist[edge_n+1][3] = in_s24;
      hist[edge_n+1][4] = in_x23;
      hist[edge_n+1][5] = in_x24;
    end
    pre_x = mv[act] & rdy[act];
    pre_s = mv[act] & ~rdy[act];
    pd    = md[act];
    ps    = msel[act];
    pi    = midx[act];
    pl    = mlast[act];
    @(posedge clk);
    edge_n++;
    #1;
    if (pre_x) begin
      t.d = pd;
      t.s = ps;
      t.i = pi;
      t.l = pl;
      t.e = edge_n;
      xq.push_back(t);
    end
    if (pre_s) begin
      check("stall_valid", mv[act], 1'b1);
      check("stall_data", md[act], pd);
      check("stall_sel", msel[act], ps);
      check("stall_idx", midx[act], pi);
      check("stall_last", mlast[act], pl);
    end
  endtask

  task automatic reset_checks();
    check("rst_valid", mv[0], 1'b0);
    check("rst_data", md[0], 32'h0);
    check("rst_sel", msel[0], 3'd0);
    check("rst_idx", midx[0], 4'd0);
    check("rst_last", mlast[0], 1'b0);
    check("rst_busy", mbusy[0], 1'b0);
    check("rst_done", mdone[0], 1'b0);
    check("rst_err", merr[0], 1'b0);
  endtask

  // Runs one frame on instance dd and checks it against the input history.
  // mode 0: ready held high; mode 1: ready toggles 1,0,0,1.
  task automatic run_frame(input int dd, input int lat, input int n, input int mode,
                           input int extra_off, input bit issue, input bit restart);
    int k, fv, done_e, steps;
    act = dd;
    xq.delete();
    fv     = -1;
    done_e = -1;
    rdy[dd] = 1'b1;
    if (issue) begin
      st[dd] = 1'b1;
      step();
      st[dd] = 1'b0;
    end
    k = edge_n;
    check("busy_after_start", mbusy[dd], 1'b1);
    check("err_clear_on_start", merr[dd], 1'b0);
    if (fv < 0 && mv[dd]) fv = edge_n;
    steps = 0;
    while (done_e < 0 && steps < 1000) begin
      rdy[dd] = (mode == 0) ? 1'b1 : ((steps % 4 == 0) || (steps % 4 == 3));
      st[dd]  = (extra_off > 0) && (edge_n + 1 == k + extra_off);
      step();
      st[dd] = 1'b0;
      steps++;
      if (fv < 0 && mv[dd]) fv = edge_n;
      if (extra_off > 0 && edge_n == k + extra_off) check("err_on_busy_start", merr[dd], 1'b1);
      if (mdone[dd]) begin
        done_e = edge_n;
        check("busy_low_on_done", mbusy[dd], 1'b0);
      end
    end
    check("frame_done_seen", done_e >= 0, 1'b1);
    check("first_valid_edge", fv, k + lat + n - 1);
    check("word_count", xq.size(), 6 * n);
    foreach (xq[j]) begin
      check("word_idx", xq[j].i, j / 6);
      check("word_sel", xq[j].s, j % 6);
      check("word_data", xq[j].d, hist[k+lat+j/6][j%6]);
      check("word_last", xq[j].l, j == 6 * n - 1);
    end
    if (xq.size() > 0) begin
      check("done_after_last", done_e, xq[$].e);
      if (mode == 0) check("last_xfer_edge", xq[$].e, k + lat + n - 1 + 6 * n);
    end
    check("err_at_end", merr[dd], extra_off > 0);
    rdy[dd] = 1'b1;
    st[dd]  = restart;
    step();
    st[dd] = 1'b0;
    check("done_one_cycle", mdone[dd], 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1);
  end

  initial begin
    int k;
    n_checks = 0;
    n_errors = 0;
    edge_n   = 0;
    act      = 0;
    st       = 2'b00;
    rdy      = 2'b11;
    in_c14 = '0; in_s14 = '0; in_c24 = '0; in_s24 = '0; in_x23 = '0; in_x24 = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1 reset_checks();
    repeat (3) step();
    rst = 1'b1;
    while (edge_n < 9) step();

    // Basic frame: start sampled at edge 10.
    run_frame(0, 8, 10, 0, -1, 1'b1, 1'b0);
    repeat (3) step();

    // Backpressure.
    run_frame(0, 8, 10, 1, -1, 1'b1, 1'b0);
    repeat (2) step();

    // Start while busy, 30 edges after the accepted start (inside DRAIN).
    run_frame(0, 8, 10, 0, 30, 1'b1, 1'b0);
    repeat (2) step();
    run_frame(0, 8, 10, 0, -1, 1'b1, 1'b0);
    repeat (2) step();

    // Reset twelve edges after start, in the middle of CAPTURE.
    act   = 0;
    st[0] = 1'b1;
    step();
    st[0] = 1'b0;
    k = edge_n;
    while (edge_n < k + 12) step();
    rst = 1'b0;
    #1 reset_checks();
    repeat (2) step();
    rst = 1'b1;
    step();
    check("idle_after_reset", mbusy[0], 1'b0);
    run_frame(0, 8, 10, 0, -1, 1'b1, 1'b0);
    repeat (2) step();

    // Boundary instance: N=1, LATENCY=1, second start in the done cycle.
    run_frame(1, 1, 1, 0, -1, 1'b1, 1'b1);
    run_frame(1, 1, 1, 0, -1, 1'b0, 1'b0);
    check("b2b_err_stays_low", merr[1], 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/systolic_collector.md
# systolic_collector

Output-side companion of the systolic array. The array's input sequencer streams `x01..x04` after a `start` pulse. This block is the other end of that path. It sees the same `start` pulse and waits the array's fixed pipeline latency. It then captures `N` consecutive output samples (`c14, s14, c24, s24, x23, x24`) into an internal buffer. Finally it drains the buffer word by word over a valid/ready stream to the downstream consumer (result RAM or host bridge).

## Interface
Parameters:
- `W`, 32: data width of every array output word.
- `N`, 10: samples captured per frame; legal range 1..16.
- `LATENCY`, 8: cycles from the `start` sampling edge to the edge at which sample 0 is valid; legal range 1..255.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle frame start, the same pulse driven to the array.
- `c14, s14, c24, s24, x23, x24`  in  W each  array outputs.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  consumer ready.
- `m_data`  out  W  stream word.
- `m_sel`  out  3  word tag: 0=c14, 1=s14, 2=c24, 3=s24, 4=x23, 5=x24.
- `m_idx`  out  4  sample index, 0..N-1.
- `m_last`  out  1  high on the final word of the frame (idx N-1, sel 5).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the final word transfers.
- `err`  out  1  sticky flag: a `start` arrived while busy.

## Operation
- Buffer: `N` entries × 6 words × W bits, register file or inferred RAM.
- FSM states: IDLE, WAIT, CAPTURE, DRAIN.
- **IDLE**
  - On `start`=1, go to WAIT, load the latency counter with `LATENCY-1`, and clear `err`.
  - If `LATENCY`=1, go directly to CAPTURE.
- **WAIT**
  - Decrement the counter each cycle.
  - When it reaches 0, go to CAPTURE with the sample counter at 0.
- **CAPTURE**
  - Each cycle, write all six inputs to entry `sample`, then increment `sample`.
  - After the write of sample N-1, go to DRAIN with the read pointer at (idx 0, sel 0).
- **DRAIN**
  - `m_valid`=1 and `m_data` = buffer[idx][sel].
  - On `m_valid & m_ready`, advance sel 0→5, then reset sel to 0 and increment idx.
  - A transfer with `m_last`=1 goes to IDLE and pulses `done`.
- Stream rule: `m_data`, `m_sel`, `m_idx` and `m_last` hold stable while `m_valid` is high and `m_ready` is low. `m_valid` never drops without a transfer.
- `start` while busy is ignored for sequencing and sets `err`=1. `err` holds until the next accepted `start` in IDLE.
- No arithmetic is performed on the data; words pass through unmodified at width W.

## Timing
- Reset values: `m_valid`=0, `m_data`=0, `m_sel`=0, `m_idx`=0, `m_last`=0, `busy`=0, `done`=0, `err`=0; FSM in IDLE; all counters 0. Buffer contents are don't-care.
- Reset asserted mid-frame aborts immediately, with no partial drain. The next frame needs a fresh `start`.
- Capture timing:
  - `start` is sampled high at edge k.
  - Sample i is captured at edge k+LATENCY+i, for i = 0..N-1.
  - `busy` goes high after edge k.
- Drain timing:
  - `m_valid` rises after edge k+LATENCY+N-1.
  - With `m_ready` held at 1, one word transfers per cycle; the last word transfers at edge k+LATENCY+N-1+6N.
- Completion:
  - `done` is high for exactly the cycle after the final transfer.
  - `busy` is 0 in that same cycle.
- A `start` in the same cycle as `done` is accepted, because the FSM is already in IDLE.
- A `start` at the final-transfer edge is still busy: it is ignored and sets `err`.
- Frame length is 6N words; `m_last` is asserted exactly once per frame.

## Test plan
1. **Basic frame.** Defaults (N=10, LATENCY=8). Pulse `start` at edge 10. Drive `x23` = 0x100+cycle and the other outputs with distinct counters. Hold `m_ready`=1.
   - Expect sample 0 taken from edge 18.
   - Expect 60 words, the first `m_valid` after edge 27, and the final transfer at edge 87.
   - Expect `m_last` only on idx 9 / sel 5 and `done` for one cycle.
2. **Backpressure.** As test 1, with `m_ready` toggling 1,0,0,1 repeatedly.
   - Words are identical and in the same order as test 1.
   - Outputs are stable during stalls, and `done` follows the 60th transfer.
3. **Start while busy.** Pulse `start` again at edge 40, during DRAIN.
   - Sequencing is unchanged and `err`=1 until the next idle `start`.
   - A new frame then completes with `err` cleared.
4. **Reset mid-CAPTURE.** Assert `rst`=0 at edge 22.
   - All outputs read 0 asynchronously and `busy`=0.
   - After release, a new `start` yields a correct, complete frame.
5. **Boundary parameters.** N=1, LATENCY=1.
   - Capture happens at the edge after `start`, followed by 6 words with `m_last` on sel 5.
   - A back-to-back `start` during the `done` cycle is accepted and `err` stays 0.
